// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch/data request and memory bus bundle for mem_arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_read;
  logic        d_write;
  logic        d_byte;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  if_req, if_addr, d_read, d_write, d_byte, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_read, d_write, d_byte, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-port fixed-latency memory
// Optional round-robin arbitration on simultaneous requests: MEM_ARB_ROUND_ROBIN_EN
module mem_arbiter #(
  parameter int MEM_LATENCY = 3,
  parameter int CNT_W       = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             owner_d;
  logic             lat_we;
  logic             lat_byte;
  logic [1:0]       lat_sel;
  logic             d_req;
  logic             grant_d;
  logic             grant_i;
  logic [7:0]       rd_byte;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic             last_owner_d;
`endif

  always_comb begin
    d_req = bus.d_read | bus.d_write;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a tie the side that did not win last time goes first
    grant_d = d_req & (~bus.if_req | ~last_owner_d);
`else
    grant_d = d_req;
`endif
    grant_i = bus.if_req & ~grant_d;
  end

  always_comb begin
    rd_byte = bus.mem_rdata[7:0];
    case (lat_sel)
      2'd1:    rd_byte = bus.mem_rdata[15:8];
      2'd2:    rd_byte = bus.mem_rdata[23:16];
      2'd3:    rd_byte = bus.mem_rdata[31:24];
      default: rd_byte = bus.mem_rdata[7:0];
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      owner_d       <= 1'b0;
      lat_we        <= 1'b0;
      lat_byte      <= 1'b0;
      lat_sel       <= 2'd0;
      bus.if_ready  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_ready   <= 1'b0;
      bus.d_rdata   <= '0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'h0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_owner_d  <= 1'b0;
`endif
    end else begin
      bus.if_ready <= 1'b0;
      bus.d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            state       <= BUSY;
            bus.busy    <= 1'b1;
            bus.mem_req <= 1'b1;
            cnt         <= CNT_W'(MEM_LATENCY - 1);
            owner_d     <= grant_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_d <= grant_d;
`endif
            if (grant_d) begin
              lat_we        <= bus.d_write;
              lat_byte      <= bus.d_byte;
              lat_sel       <= bus.d_addr[1:0];
              bus.mem_we    <= bus.d_write;
              bus.mem_addr  <= {bus.d_addr[31:2], 2'b00};
              bus.mem_be    <= (bus.d_write && bus.d_byte) ? (4'b0001 << bus.d_addr[1:0]) : 4'hF;
              bus.mem_wdata <= bus.d_byte ? {4{bus.d_wdata[7:0]}} : bus.d_wdata;
            end else begin
              lat_we        <= 1'b0;
              lat_byte      <= 1'b0;
              lat_sel       <= 2'd0;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= {bus.if_addr[31:2], 2'b00};
              bus.mem_be    <= 4'hF;
              bus.mem_wdata <= '0;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state         <= DONE;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_be    <= 4'h0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            if (owner_d) begin
              bus.d_ready <= 1'b1;
              // Stores leave the last load result in place
              if (!lat_we) begin
                bus.d_rdata <= lat_byte ? {24'b0, rd_byte} : bus.mem_rdata;
              end
            end else begin
              bus.if_ready <= 1'b1;
              bus.if_rdata <= bus.mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single-port, fixed-latency memory between the fetch stage (I-side, word reads) and the memory stage (D-side, using the decoder's mem_read / mem_write / mem_byte flags).
- Arbitrates requests, sequences each transaction with a latency counter and performs byte-lane steering.
- Returns a one-cycle ready pulse to the winner; the pipeline controller stalls the corresponding stage while ready is low.

Parameters:
- MEM_LATENCY, 3, memory cycles from request to valid mem_rdata; legal range 1..15.
- CNT_W, 4, latency counter width; must satisfy 2^CNT_W > MEM_LATENCY.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- if_req  input  1  fetch requests a word read; held until if_ready
- if_addr  input  32  fetch byte address; bits [1:0] ignored
- if_ready  output  1  one-cycle pulse: if_rdata valid, fetch done
- if_rdata  output  32  fetched instruction word
- d_read  input  1  decoder mem_read
- d_write  input  1  decoder mem_write
- d_byte  input  1  decoder mem_byte
- d_addr  input  32  data byte address (ALU result)
- d_wdata  input  32  store data; byte stores use bits [7:0]
- d_ready  output  1  one-cycle pulse: data access done, d_rdata valid for loads
- d_rdata  output  32  load data; byte loads zero-extended
- mem_req  output  1  memory access in progress
- mem_we  output  1  write enable
- mem_be  output  4  byte enables, little-endian
- mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  output  32  write data
- mem_rdata  input  32  memory read data, valid in the last BUSY cycle
- busy  output  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate, also mid-transaction):
  - state = IDLE, counter = 0, all latched fields = 0.
  - All outputs 0, including if_rdata and d_rdata.
  - mem_req drops in the same cycle; any in-flight access is abandoned with no ready pulse.
- States: IDLE, BUSY, DONE.
- IDLE:
  - d_req = d_read | d_write.
  - d_req=1: grant D. Otherwise if_req=1: grant I. Neither: stay in IDLE.
  - D has priority on a simultaneous request.
  - On a grant, latch owner, we, byte, addr, wdata; counter = MEM_LATENCY-1; go to BUSY.
- BUSY:
  - mem_req=1; mem_* driven only from latched values, so input changes are ignored.
  - counter decrements each cycle.
  - When counter==0: capture read data into the owner's rdata register and go to DONE.
  - BUSY therefore lasts exactly MEM_LATENCY cycles.
- DONE:
  - mem_req=0; the owner's ready = 1 for exactly this cycle; then go to IDLE.
  - No grant is made in DONE, so a request still held in this cycle is not re-granted.
- Latency and throughput:
  - Request sampled in IDLE at edge N; ready is high during cycle N+MEM_LATENCY+1.
  - One transaction per MEM_LATENCY+2 cycles.
- d_read & d_write both high: treated as a write.
- Word access: mem_be=4'hF; mem_wdata=wdata; d_rdata=mem_rdata.
- Byte write:
  - mem_be = 4'b0001 << addr[1:0].
  - mem_wdata = {4{wdata[7:0]}}.
- Byte read:
  - mem_be=4'hF.
  - d_rdata = {24'b0, mem_rdata[8*addr[1:0] +: 8]}.
- I-side: always a word read; mem_we=0; mem_be=4'hF.
- Write transactions leave d_rdata unchanged.
- if_rdata and d_rdata hold their last captured value until the next completion for that owner.
- A requester dropping its request during BUSY does not abort the transaction; it completes and the ready pulse is still issued.
- mem_we, mem_be, mem_addr and mem_wdata are 0 whenever mem_req=0.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN
- Defined:
  - A last_owner register (reset value I) is updated at each grant.
  - On a simultaneous request in IDLE, the side that is not last_owner wins.
  - A single requester is always granted immediately.
- Not defined: fixed D-over-I priority; no last_owner register.

Test Plan:
- Reset, MEM_LATENCY=3, if_req=1, if_addr=32'h0000_0104, memory returns 32'hDEAD_BEEF:
  - mem_req high for 3 cycles with mem_addr=32'h0000_0104, mem_be=4'hF, mem_we=0.
  - if_ready pulses one cycle, 4 cycles after the grant edge; if_rdata=32'hDEAD_BEEF.
- Same cycle: if_req=1 and d_read=1 (d_addr=32'h40):
  - D served first, d_ready pulses; I granted in the IDLE cycle after DONE, if_ready pulses 5 cycles later.
  - With MEM_ARB_ROUND_ROBIN_EN after reset: D is still first (last_owner=I); a second simultaneous request is then granted to I.
- Byte store: d_write=1, d_byte=1, d_addr=32'h0000_0013, d_wdata=32'h0000_00A5:
  - mem_addr=32'h10, mem_be=4'b1000, mem_we=1, mem_wdata=32'hA5A5_A5A5.
- Byte load: d_read=1, d_byte=1, d_addr=32'h22, mem_rdata=32'h1122_3344:
  - d_rdata=32'h0000_0022.
  - Word load at the same address returns 32'h1122_3344 with mem_addr=32'h20.
- Reset asserted in the 2nd BUSY cycle of a D read:
  - mem_req and busy go 0 immediately; no d_ready pulse; d_rdata=0.
  - After reset is released, a new if_req is served normally.
- Requester holds d_read high through DONE:
  - Exactly one d_ready pulse.
  - Re-grant occurs only at the following IDLE edge; no grant in DONE.
